// File: rtl/jtag_bridge_pkg.sv
// Shared types and constants for the JTAG user-DR to memory bridge.
package jtag_bridge_pkg;

  // Command field at the top of each DR frame
  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_READ   = 2'b01,
    CMD_WRITE  = 2'b10,
    CMD_STREAM = 2'b11
  } cmd_e;

  localparam int unsigned CMD_W = 2;

  // Status field occupies the top STAT_W bits of the captured frame
  localparam int unsigned STAT_W      = 2;
  localparam int unsigned ST_ERR_BIT  = 1;
  localparam int unsigned ST_BUSY_BIT = 0;

  // DR frame length: {cmd, addr, data}
  function automatic int unsigned frame_len(input int unsigned aw, input int unsigned dw);
    return CMD_W + aw + dw;
  endfunction

endpackage

// File: rtl/jtag_dr_shifter.sv
// DR shift register with saturating bit counter, stream sub-word counter and capture load.
module jtag_dr_shifter #(
  parameter int unsigned L   = 43,
  parameter int unsigned DW  = 32,
  parameter int unsigned BCW = 6,
  parameter int unsigned SCW = 5
) (
  input  logic           clk_p,
  input  logic           rst_top,
  input  logic           i_tap_reset,
  input  logic           i_cap,
  input  logic           i_upd,
  input  logic           i_shift,
  input  logic           i_stream,
  input  logic           i_tdi,
  input  logic [L-1:0]   i_cap_data,
  output logic [L-1:0]   o_sr,
  output logic [BCW-1:0] o_bitcnt,
  output logic [SCW-1:0] o_subcnt,
  output logic           o_tdo
);

  logic [L-1:0]   r_sr;
  logic [BCW-1:0] r_bitcnt;
  logic [SCW-1:0] r_subcnt;

  // Strobes arrive already prioritised (capture > update > shift) by the parent
  always_ff @(posedge clk_p or negedge rst_top) begin
    if (!rst_top) begin
      r_sr     <= '0;
      r_bitcnt <= '0;
      r_subcnt <= '0;
    end else if (i_tap_reset) begin
      r_bitcnt <= '0;
      r_subcnt <= '0;
    end else if (i_cap) begin
      r_sr     <= i_cap_data;
      r_bitcnt <= '0;
      r_subcnt <= '0;
    end else if (i_upd) begin
      r_subcnt <= '0;
    end else if (i_shift) begin
      r_sr <= {i_tdi, r_sr[L-1:1]};
      if (r_bitcnt != BCW'(L)) begin
        r_bitcnt <= r_bitcnt + BCW'(1);
      end
      if (i_stream) begin
        r_subcnt <= (r_subcnt == SCW'(DW - 1)) ? '0 : r_subcnt + SCW'(1);
      end
    end
  end

  assign o_sr     = r_sr;
  assign o_bitcnt = r_bitcnt;
  assign o_subcnt = r_subcnt;
  assign o_tdo    = r_sr[0];

endmodule

// File: rtl/jtag_mem_bridge.sv
// JTAG user-DR to single-port memory bridge: command decode, request handshake, status.
module jtag_mem_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int unsigned AW = 9,
  parameter int unsigned DW = 32
) (
  input  logic                     clk_p,
  input  logic                     rst_top,
  input  logic                     sel,
  input  logic                     capture,
  input  logic                     shift,
  input  logic                     update,
  input  logic                     tap_reset,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     err_o,
  output logic                     busy_o,
  output logic [$clog2(AW+DW+3)-1:0] dbg_bitcnt
);

  localparam int unsigned L   = frame_len(AW, DW);
  localparam int unsigned BCW = $clog2(L + 1);
  localparam int unsigned SCW = (DW > 1) ? $clog2(DW) : 1;

  logic          r_req, r_we, r_rd_pend, r_busy, r_err, r_stream;
  logic [AW-1:0] r_addr, r_ptr, r_last_addr;
  logic [DW-1:0] r_wdata, r_rdata_q;
  logic [BCW-1:0] r_dbg_bitcnt;

  logic           w_cap, w_upd, w_shf;
  logic [L-1:0]   w_sr, w_sr_sh, w_cap_data;
  logic [BCW-1:0] w_bitcnt;
  logic [SCW-1:0] w_subcnt;
  logic [STAT_W-1:0] w_status;
  cmd_e           w_cmd;
  logic           w_first, w_next_word;
  logic           w_commit, w_c_we, w_err_set, w_stream_nxt, w_req_nxt, w_pend_nxt;
  logic [AW-1:0]  w_c_addr, w_ptr_nxt;
  logic [DW-1:0]  w_c_data;

  // TAP strobes with capture > update > shift priority; tap_reset masks them all
  assign w_cap = sel & capture & ~tap_reset;
  assign w_upd = sel & update & ~capture & ~tap_reset;
  assign w_shf = sel & shift & ~capture & ~update & ~tap_reset;

  // Captured frame: {err, busy, last_addr, rdata_q}
  always_comb begin
    w_status              = '0;
    w_status[ST_ERR_BIT]  = r_err;
    w_status[ST_BUSY_BIT] = r_busy;
    w_cap_data            = {w_status, r_last_addr, r_rdata_q};
  end

  jtag_dr_shifter #(
    .L   (L),
    .DW  (DW),
    .BCW (BCW),
    .SCW (SCW)
  ) u_shifter (
    .clk_p       (clk_p),
    .rst_top     (rst_top),
    .i_tap_reset (tap_reset),
    .i_cap       (w_cap),
    .i_upd       (w_upd),
    .i_shift     (w_shf),
    .i_stream    (r_stream),
    .i_tdi       (tdi),
    .i_cap_data  (w_cap_data),
    .o_sr        (w_sr),
    .o_bitcnt    (w_bitcnt),
    .o_subcnt    (w_subcnt),
    .o_tdo       (tdo)
  );

  // Contents of sr after this cycle's shift, so shift-edge commits see the finished word
  assign w_sr_sh = {tdi, w_sr[L-1:1]};
  assign w_cmd   = cmd_e'(w_sr[L-1 -: CMD_W]);

  assign w_first     = w_shf & ~r_stream & (w_bitcnt == BCW'(L - 1)) &
                       (w_sr_sh[L-1 -: CMD_W] == CMD_STREAM);
  assign w_next_word = w_shf & r_stream & (w_subcnt == SCW'(DW - 1));

  // Command decode: which access to commit, pointer and stream bookkeeping, error sources
  always_comb begin
    w_commit     = 1'b0;
    w_c_we       = 1'b0;
    w_c_addr     = r_ptr;
    w_c_data     = '0;
    w_err_set    = 1'b0;
    w_ptr_nxt    = r_ptr;
    w_stream_nxt = r_stream;
    if (tap_reset || w_cap) begin
      w_stream_nxt = 1'b0;
    end else if (w_upd) begin
      w_stream_nxt = 1'b0;
      if (r_stream) begin
        if (w_subcnt != '0) w_err_set = 1'b1;
      end else if (w_bitcnt != BCW'(L)) begin
        w_err_set = 1'b1;
      end else begin
        w_c_addr = w_sr[DW +: AW];
        w_c_data = w_sr[0 +: DW];
        case (w_cmd)
          CMD_NOP:   w_ptr_nxt = w_sr[DW +: AW];
          CMD_READ:  begin
            w_commit  = 1'b1;
            w_ptr_nxt = w_sr[DW +: AW] + AW'(1);
          end
          CMD_WRITE: begin
            w_commit  = 1'b1;
            w_c_we    = 1'b1;
            w_ptr_nxt = w_sr[DW +: AW] + AW'(1);
          end
          default: ;
        endcase
      end
    end else if (w_first) begin
      w_commit     = 1'b1;
      w_c_we       = 1'b1;
      w_c_addr     = w_sr_sh[DW +: AW];
      w_c_data     = w_sr_sh[0 +: DW];
      w_ptr_nxt    = w_sr_sh[DW +: AW] + AW'(1);
      w_stream_nxt = 1'b1;
    end else if (w_next_word) begin
      w_commit  = 1'b1;
      w_c_we    = 1'b1;
      w_c_addr  = r_ptr;
      w_c_data  = w_sr_sh[L-1 -: DW];
      w_ptr_nxt = r_ptr + AW'(1);
    end
    if (w_commit && r_busy)        w_err_set = 1'b1;
    if (mem_rvalid && !r_rd_pend)  w_err_set = 1'b1;
  end

  // Request / read-pending next state; a commit is only accepted while idle
  always_comb begin
    w_req_nxt  = r_req;
    w_pend_nxt = r_rd_pend;
    if (r_req && mem_gnt) begin
      w_req_nxt = 1'b0;
      if (!r_we) w_pend_nxt = 1'b1;
    end
    if (r_rd_pend && mem_rvalid) w_pend_nxt = 1'b0;
    if (w_commit && !r_busy)     w_req_nxt  = 1'b1;
  end

  // Bridge state: memory port, status, pointer and read-data holding register
  always_ff @(posedge clk_p or negedge rst_top) begin
    if (!rst_top) begin
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd_pend    <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_stream     <= 1'b0;
      r_ptr        <= '0;
      r_last_addr  <= '0;
      r_rdata_q    <= '0;
      r_dbg_bitcnt <= '0;
    end else begin
      r_req     <= w_req_nxt;
      r_rd_pend <= w_pend_nxt;
      r_busy    <= w_req_nxt | w_pend_nxt;
      r_stream  <= w_stream_nxt;
      r_ptr     <= w_ptr_nxt;
      if (w_commit && !r_busy) begin
        r_we        <= w_c_we;
        r_addr      <= w_c_addr;
        r_wdata     <= w_c_data;
        r_last_addr <= w_c_addr;
      end
      if (r_rd_pend && mem_rvalid) r_rdata_q <= mem_rdata;
      if (w_err_set)  r_err <= 1'b1;
      else if (w_cap) r_err <= 1'b0;
      if (w_upd) r_dbg_bitcnt <= w_bitcnt;
    end
  end

  assign mem_req    = r_req;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign err_o      = r_err;
  assign busy_o     = r_busy;
  assign dbg_bitcnt = r_dbg_bitcnt;

endmodule

// File: tb/tb_jtag_mem_bridge.sv
// Self-checking bench for jtag_mem_bridge with a behavioural memory and status model.
module tb_jtag_mem_bridge;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 32;
  localparam int unsigned L     = 2 + AW + DW;
  localparam int unsigned BCW   = $clog2(L + 1);
  localparam int unsigned VW    = 256;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk_p = 1'b0;
  logic rst_top = 1'b0;
  logic sel = 1'b0, capture = 1'b0, shift = 1'b0, update = 1'b0, tap_reset = 1'b0, tdi = 1'b0;
  logic tdo;
  logic mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic err_o, busy_o;
  logic [BCW-1:0] dbg_bitcnt;

  int checks = 0;
  int errors = 0;

  // Memory device behaviour
  logic [DW-1:0] dev_mem [DEPTH];
  int gnt_delay = 0;
  bit gnt_block = 1'b0;
  bit inj_rv = 1'b0;
  int wait_cnt = 0;
  bit rv_pend = 1'b0;
  logic [DW-1:0] rv_data = '0;
  int req_cycles = 0;
  logic [AW-1:0] wlog_addr[$];
  logic [DW-1:0] wlog_data[$];

  // Reference model of what the scan chain should report
  logic [DW-1:0] ref_mem [DEPTH];
  bit ref_err = 1'b0;
  logic [AW-1:0] ref_last = '0;
  logic [DW-1:0] ref_rdata = '0;

  always #5 clk_p = ~clk_p;

  jtag_mem_bridge #(.AW(AW), .DW(DW)) dut (
    .clk_p      (clk_p),
    .rst_top    (rst_top),
    .sel        (sel),
    .capture    (capture),
    .shift      (shift),
    .update     (update),
    .tap_reset  (tap_reset),
    .tdi        (tdi),
    .tdo        (tdo),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .err_o      (err_o),
    .busy_o     (busy_o),
    .dbg_bitcnt (dbg_bitcnt)
  );

  // Memory responder: grant after gnt_delay cycles, read data one cycle after grant
  initial begin
    forever begin
      @(negedge clk_p);
      mem_rvalid = rv_pend | inj_rv;
      mem_rdata  = rv_pend ? rv_data : DW'($urandom);
      rv_pend    = 1'b0;
      inj_rv     = 1'b0;
      mem_gnt    = 1'b0;
      if (rst_top && mem_req) begin
        req_cycles++;
        if (!gnt_block && wait_cnt >= gnt_delay) begin
          mem_gnt  = 1'b1;
          wait_cnt = 0;
          if (mem_we) begin
            dev_mem[mem_addr] = mem_wdata;
            wlog_addr.push_back(mem_addr);
            wlog_data.push_back(mem_wdata);
          end else begin
            rv_pend = 1'b1;
            rv_data = dev_mem[mem_addr];
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_p);
  endtask

  task automatic clear_log();
    wlog_addr.delete();
    wlog_data.delete();
    req_cycles = 0;
  endtask

  function automatic logic [VW-1:0] mk(input logic [1:0] cmd, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
    logic [VW-1:0] v;
    v = '0;
    v[L-1:0] = {cmd, a, d};
    return v;
  endfunction

  // Capture, shift nbits LSB first (recording what comes out), optional Update
  task automatic scan(input logic [VW-1:0] bits, input int nbits, input bit do_upd,
                      output logic [L-1:0] cap);
    cap = '0;
    @(negedge clk_p);
    sel = 1'b1; capture = 1'b1;
    @(negedge clk_p);
    capture = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      shift = 1'b1;
      tdi   = bits[i];
      if (i < int'(L)) cap[i] = tdo;
      @(negedge clk_p);
    end
    shift = 1'b0;
    tdi   = 1'b0;
    if (do_upd) begin
      update = 1'b1;
      @(negedge clk_p);
      update = 1'b0;
    end
    sel = 1'b0;
  endtask

  task automatic test_reset();
    logic [L-1:0] cap;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL reset_status: got err=%b busy=%b want 0 0", err_o, busy_o); end
    checks++; if (dbg_bitcnt !== '0 || tdo !== 1'b0) begin errors++; $display("FAIL reset_dbg_tdo: got bitcnt=%0d tdo=%b want 0 0", dbg_bitcnt, tdo); end
    scan(mk(2'b00, 9'h000, '0), L, 1'b1, cap);
    checks++; if (cap !== '0) begin errors++; $display("FAIL reset_capture: got %h want 0", cap); end
    checks++; if (dbg_bitcnt !== BCW'(L)) begin errors++; $display("FAIL reset_full_bitcnt: got %0d want %0d", dbg_bitcnt, L); end
  endtask

  task automatic test_write_read();
    logic [L-1:0] cap;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    gnt_delay = 2;
    clear_log();
    scan(mk(2'b10, 9'h005, 32'hDEADBEEF), L, 1'b1, cap);
    idle(8);
    ref_mem[5] = 32'hDEADBEEF; ref_last = 9'h005;
    checks++;
    if (wlog_addr.size() != 1 || wlog_addr[0] !== 9'h005 || wlog_data[0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_fixed: got %0d writes first %h=%h want 1 write 005=deadbeef",
                         wlog_addr.size(), wlog_addr.size() > 0 ? wlog_addr[0] : 9'h0,
                         wlog_data.size() > 0 ? wlog_data[0] : 32'h0);
    end
    scan(mk(2'b01, 9'h005, 32'h12345678), L, 1'b1, cap);
    idle(8);
    ref_rdata = ref_mem[5];
    scan(mk(2'b00, 9'h000, '0), L, 1'b1, cap);
    checks++; if (cap !== {1'b0, 1'b0, ref_last, ref_rdata}) begin errors++; $display("FAIL rd_fixed_capture: got %h want %h", cap, {1'b0, 1'b0, ref_last, ref_rdata}); end
    for (int it = 0; it < 6; it++) begin
      a = AW'($urandom);
      d = DW'($urandom);
      gnt_delay = int'($urandom_range(0, 3));
      clear_log();
      scan(mk(2'b10, a, d), L, 1'b1, cap);
      idle(8);
      ref_mem[a] = d; ref_last = a;
      checks++;
      if (wlog_addr.size() != 1 || wlog_addr[0] !== a || wlog_data[0] !== d) begin
        errors++; $display("FAIL wr_rand%0d: got %0d writes want 1 write %h=%h", it, wlog_addr.size(), a, d);
      end
      scan(mk(2'b01, a, DW'($urandom)), L, 1'b1, cap);
      checks++; if (cap !== {1'b0, 1'b0, ref_last, ref_rdata}) begin errors++; $display("FAIL wr_rand%0d_status: got %h want %h", it, cap, {1'b0, 1'b0, ref_last, ref_rdata}); end
      idle(8);
      ref_rdata = ref_mem[a];
      scan(mk(2'b00, AW'($urandom), '0), L, 1'b1, cap);
      checks++; if (cap !== {1'b0, 1'b0, ref_last, ref_rdata}) begin errors++; $display("FAIL rd_rand%0d: got %h want %h", it, cap, {1'b0, 1'b0, ref_last, ref_rdata}); end
    end
  endtask

  task automatic test_stream();
    logic [L-1:0] cap;
    logic [VW-1:0] v;
    logic [DW-1:0] w [4];
    logic [AW-1:0] a, ea;
    int n;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        a = 9'h1FE; n = 3; w[0] = 32'hA; w[1] = 32'hB; w[2] = 32'hC; w[3] = '0;
        gnt_delay = 1;
      end else begin
        a = AW'($urandom); n = int'($urandom_range(1, 4));
        for (int k = 0; k < 4; k++) w[k] = DW'($urandom);
        gnt_delay = int'($urandom_range(0, 3));
      end
      v = mk(2'b11, a, w[0]);
      for (int k = 1; k < n; k++) v[L + (k - 1) * DW +: DW] = w[k];
      clear_log();
      scan(v, int'(L) + (n - 1) * int'(DW), 1'b1, cap);
      idle(8);
      checks++; if (wlog_addr.size() != n) begin errors++; $display("FAIL stream%0d_count: got %0d want %0d", it, wlog_addr.size(), n); end
      for (int k = 0; k < n && k < int'(wlog_addr.size()); k++) begin
        ea = AW'((int'(a) + k) % int'(DEPTH));
        checks++;
        if (wlog_addr[k] !== ea || wlog_data[k] !== w[k]) begin
          errors++; $display("FAIL stream%0d_word%0d: got %h=%h want %h=%h", it, k, wlog_addr[k], wlog_data[k], ea, w[k]);
        end
        ref_mem[ea] = w[k];
        ref_last = ea;
      end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL stream%0d_err: got %b want 0", it, err_o); end
    end
    scan(mk(2'b00, '0, '0), L, 1'b1, cap);
    checks++; if (cap !== {1'b0, 1'b0, ref_last, ref_rdata}) begin errors++; $display("FAIL stream_status: got %h want %h", cap, {1'b0, 1'b0, ref_last, ref_rdata}); end
  endtask

  task automatic test_short_frame();
    logic [L-1:0] cap;
    clear_log();
    gnt_delay = 0;
    scan(mk(2'b10, AW'($urandom), DW'($urandom)), 40, 1'b1, cap);
    idle(4);
    checks++; if (req_cycles != 0 || wlog_addr.size() != 0) begin errors++; $display("FAIL short_noreq: got req_cycles=%0d writes=%0d want 0 0", req_cycles, wlog_addr.size()); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL short_err: got %b want 1", err_o); end
    checks++; if (dbg_bitcnt !== BCW'(40)) begin errors++; $display("FAIL short_bitcnt: got %0d want 40", dbg_bitcnt); end
    scan(mk(2'b00, '0, '0), L, 1'b1, cap);
    checks++; if (cap !== {1'b1, 1'b0, ref_last, ref_rdata}) begin errors++; $display("FAIL short_cap1: got %h want %h", cap, {1'b1, 1'b0, ref_last, ref_rdata}); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL short_clear: got %b want 0", err_o); end
    scan(mk(2'b00, '0, '0), L, 1'b1, cap);
    checks++; if (cap !== {1'b0, 1'b0, ref_last, ref_rdata}) begin errors++; $display("FAIL short_cap2: got %h want %h", cap, {1'b0, 1'b0, ref_last, ref_rdata}); end
  endtask

  task automatic test_overrun();
    logic [L-1:0] cap;
    logic [VW-1:0] v;
    logic [AW-1:0] a;
    logic [DW-1:0] d0, d1;
    a = AW'($urandom); d0 = DW'($urandom); d1 = DW'($urandom);
    gnt_block = 1'b1;
    clear_log();
    v = mk(2'b11, a, d0);
    v[L +: DW] = d1;
    scan(v, int'(L + DW), 1'b1, cap);
    idle(3);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a || mem_wdata !== d0) begin
      errors++; $display("FAIL ovr_held: got req=%b we=%b %h=%h want 1 1 %h=%h", mem_req, mem_we, mem_addr, mem_wdata, a, d0);
    end
    checks++; if (err_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL ovr_status: got err=%b busy=%b want 1 1", err_o, busy_o); end
    gnt_block = 1'b0;
    idle(6);
    checks++; if (wlog_addr.size() != 1 || wlog_addr[0] !== a || wlog_data[0] !== d0) begin
      errors++; $display("FAIL ovr_writes: got %0d writes want 1 write %h=%h", wlog_addr.size(), a, d0);
    end
    checks++; if (busy_o !== 1'b0 || err_o !== 1'b1) begin errors++; $display("FAIL ovr_after_gnt: got busy=%b err=%b want 0 1", busy_o, err_o); end
    ref_mem[a] = d0; ref_last = a;
    scan(mk(2'b00, '0, '0), L, 1'b1, cap);
    checks++; if (cap !== {1'b1, 1'b0, ref_last, ref_rdata}) begin errors++; $display("FAIL ovr_cap: got %h want %h", cap, {1'b1, 1'b0, ref_last, ref_rdata}); end
  endtask

  task automatic test_partial();
    logic [L-1:0] cap;
    logic [VW-1:0] v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom); d = DW'($urandom);
    gnt_delay = 1;
    clear_log();
    v = mk(2'b11, a, d);
    v[L +: 17] = 17'($urandom);
    scan(v, int'(L) + 17, 1'b1, cap);
    idle(6);
    checks++; if (wlog_addr.size() != 1 || wlog_addr[0] !== a || wlog_data[0] !== d) begin
      errors++; $display("FAIL part_writes: got %0d writes want 1 write %h=%h", wlog_addr.size(), a, d);
    end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL part_err: got %b want 1", err_o); end
    ref_mem[a] = d; ref_last = a;
    scan(mk(2'b00, '0, '0), L, 1'b1, cap);
    checks++; if (cap !== {1'b1, 1'b0, ref_last, ref_rdata}) begin errors++; $display("FAIL part_cap: got %h want %h", cap, {1'b1, 1'b0, ref_last, ref_rdata}); end
  endtask

  task automatic test_unsolicited();
    logic [L-1:0] cap;
    inj_rv = 1'b1;
    idle(3);
    checks++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL unsol_status: got err=%b busy=%b want 1 0", err_o, busy_o); end
    scan(mk(2'b00, '0, '0), L, 1'b1, cap);
    checks++; if (cap !== {1'b1, 1'b0, ref_last, ref_rdata}) begin errors++; $display("FAIL unsol_cap: got %h want %h", cap, {1'b1, 1'b0, ref_last, ref_rdata}); end
  endtask

  task automatic test_reset_mid_access();
    logic [L-1:0] cap;
    logic [AW-1:0] a;
    gnt_block = 1'b1;
    clear_log();
    scan(mk(2'b10, AW'($urandom), DW'($urandom)), L, 1'b1, cap);
    idle(2);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got req=%b want 1", mem_req); end
    #2;
    rst_top = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got req=%b busy=%b want 0 0", mem_req, busy_o); end
    @(negedge clk_p);
    rst_top = 1'b1;
    gnt_block = 1'b0;
    gnt_delay = 0;
    ref_err = 1'b0; ref_last = '0; ref_rdata = '0;
    idle(2);
    a = ref_last;
    for (int k = 0; k < int'(DEPTH); k++) if (ref_mem[k] != '0) a = AW'(k);
    scan(mk(2'b01, a, '0), L, 1'b1, cap);
    checks++; if (cap !== '0) begin errors++; $display("FAIL rstmid_cap0: got %h want 0", cap); end
    idle(8);
    ref_last = a; ref_rdata = ref_mem[a];
    scan(mk(2'b00, '0, '0), L, 1'b1, cap);
    checks++; if (cap !== {1'b0, 1'b0, ref_last, ref_rdata}) begin errors++; $display("FAIL rstmid_read: got %h want %h", cap, {1'b0, 1'b0, ref_last, ref_rdata}); end
    checks++; if (wlog_addr.size() != 0) begin errors++; $display("FAIL rstmid_nowrite: got %0d writes want 0", wlog_addr.size()); end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      dev_mem[i] = '0;
      ref_mem[i] = '0;
    end
    repeat (3) @(negedge clk_p);
    rst_top = 1'b1;
    @(negedge clk_p);
    test_reset();
    test_write_read();
    test_stream();
    test_short_frame();
    test_overrun();
    test_partial();
    test_unsolicited();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
